// File: rtl/sum_to_bcd_seq_pkg.sv
// sum_to_bcd_seq_pkg: shared FSM state encoding and BCD digit width
package sum_to_bcd_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CONVERT = 2'd1, DONE = 2'd2} state_t;
  localparam int DIGIT_W = 4;
endpackage

// File: rtl/sum_to_bcd_seq_bcd_add3_digit.sv
// bcd_add3_digit: double-dabble digit adjust, adds 3 to any digit of 5 or more
module bcd_add3_digit
  import sum_to_bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);
  assign q = d >= DIGIT_W'(5) ? d + DIGIT_W'(3) : d;
endmodule

// File: rtl/sum_to_bcd_seq.sv
// sum_to_bcd_seq: handshaked sequential binary-to-BCD converter (shift-and-add-3)
module sum_to_bcd_seq
  import sum_to_bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           bin_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DIGIT_W*DIGITS-1:0]  bcd_out
);
  localparam int BW = DIGIT_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  state_t          state, state_nx;
  logic [BW-1:0]   bcd, adj, bcd_nx;
  logic [WIDTH-1:0] bin;
  logic [CW-1:0]   cnt;
  logic            last;
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (.d(bcd[g*DIGIT_W +: DIGIT_W]), .q(adj[g*DIGIT_W +: DIGIT_W]));
  end
  assign bcd_nx    = {adj[BW-2:0], bin[WIDTH-1]};
  assign last      = cnt == CW'(WIDTH - 1);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    state_nx = state == IDLE    ? (in_valid  ? CONVERT : IDLE)
             : state == CONVERT ? (last      ? DONE    : CONVERT)
             : state == DONE    ? (out_ready ? IDLE    : DONE)
             : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bcd     <= '0;
      bin     <= '0;
      cnt     <= '0;
      bcd_out <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        bin <= bin_in;
        bcd <= '0;
        cnt <= '0;
      end else if (state == CONVERT) begin
        bcd <= bcd_nx;
        bin <= bin << 1;
        cnt <= cnt + 1'b1;
        if (last) bcd_out <= bcd_nx;
      end
    end
  end
endmodule

// File: tb/tb_sum_to_bcd_seq.sv
// tb_sum_to_bcd_seq: randomized scoreboard bench for sum_to_bcd_seq against a decimal reference model
module tb_sum_to_bcd_seq;
  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [7:0]  bin_in = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [11:0] bcd_out;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [11:0] exp_q[$];
  int          acc_q[$];
  int          dq[$];
  bit          have = 0;
  logic [7:0]  pend = 0;
  bit          pv = 0, pc = 0;
  logic [11:0] pb = 0;

  sum_to_bcd_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .bin_in(bin_in),
    .out_valid(out_valid), .out_ready(out_ready), .bcd_out(bcd_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [11:0] ref_bcd(int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pv = 0;
      pc = 0;
    end else begin
      if (pc) chk("idle_after_take", int'(in_ready), 1);
      if (pv && !pc) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_bcd", int'(bcd_out), int'(pb));
      end
      if (out_valid) begin
        chk("busy_in_ready", int'(in_ready), 0);
        chk("digits_le_9", int'(bcd_out[3:0] <= 9 && bcd_out[7:4] <= 9 && bcd_out[11:8] <= 9), 1);
        if (!pv || pc) begin
          if (exp_q.size() == 0) chk("unexpected_out", int'(out_valid), 0);
          else begin
            chk("result", int'(bcd_out), int'(exp_q.pop_front()));
            chk("latency", cyc - acc_q.pop_front(), 8);
          end
        end
      end
      pc = out_valid && out_ready;
      pv = out_valid;
      pb = bcd_out;
    end
  end

  task automatic step(int vp, int rp, bit noise);
    @(posedge clk);
    #1;
    if (!have && dq.size() > 0) begin
      pend = 8'(dq.pop_front());
      have = 1;
    end else if (!have && $urandom_range(99) < vp) begin
      pend = 8'($urandom);
      have = 1;
    end
    in_valid  = in_ready ? have : (have || (noise && $urandom_range(1) == 1));
    bin_in    = (have && in_ready) ? pend : 8'($urandom);
    out_ready = $urandom_range(99) < rp;
    @(negedge clk);
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_bcd(int'(bin_in)));
      acc_q.push_back(cyc + 1);
      have = 0;
    end
  endtask

  task automatic run(int n, int vp, int rp, bit noise);
    for (int i = 0; i < n; i++) step(vp, rp, noise);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_bcd", int'(bcd_out), 0);
    @(posedge clk);
    #1 rst = 0;
    dq = '{0};
    run(30, 0, 100, 0);
    dq = '{30, 99, 255};
    run(60, 0, 100, 0);
    dq = '{42};
    run(20, 0, 0, 0);
    run(5, 0, 100, 0);
    dq = '{7, 200};
    run(40, 0, 100, 1);
    dq = '{77};
    for (int i = 0; i < 20 && have | (dq.size() > 0); i++) step(0, 100, 0);
    run(3, 0, 100, 0);
    @(posedge clk);
    #1;
    rst = 1;
    in_valid = 0;
    have = 0;
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abandoned_no_out", int'(out_valid), 0);
    end
    dq = '{128};
    run(30, 0, 100, 0);
    run(600, 50, 50, 1);
    for (int i = 0; i < 300 && (exp_q.size() > 0 || have); i++) step(0, 100, 0);
    if (exp_q.size() > 0 || have) chk("drain_timeout", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
